// File: rtl/vga_frame_checker.sv
// rtl/vga_frame_checker.sv - VGA stream checker: windowed pixel compare plus per-frame CRC-16 signature
// Results are held after a run so board LEDs can show pass/fail directly.
module vga_frame_checker #(
   parameter int NUM_CH      = 3,
   parameter int CH_WIDTH    = 8,
   parameter int VIEW_LEFT   = 160,
   parameter int VIEW_RIGHT  = 480,
   parameter int VIEW_TOP    = 120,
   parameter int VIEW_BOTTOM = 360,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         Arm,
   input  logic [1:0]                   Mode,
   input  logic [7:0]                   Frames_to_check,
   input  logic [15:0]                  Golden_signature,
   input  logic                         Vsync,
   input  logic                         Pixel_valid,
   input  logic [9:0]                   Pixel_X,
   input  logic [9:0]                   Pixel_Y,
   input  logic [NUM_CH*CH_WIDTH-1:0]   Pixel_data,
   input  logic [NUM_CH*CH_WIDTH-1:0]   Expected_data,
   output logic                         Busy,
   output logic                         Done,
   output logic                         Pass,
   output logic [CNT_WIDTH-1:0]         Mismatch_count,
   output logic                         First_mm_valid,
   output logic [9:0]                   First_mm_X,
   output logic [9:0]                   First_mm_Y,
   output logic [15:0]                  Signature,
   output logic [7:0]                   Frame_count
);

   localparam int PIX_W = NUM_CH * CH_WIDTH;
   localparam int SUM_W = CNT_WIDTH + $clog2(NUM_CH + 2) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_CHECK,
      S_FRAME_END,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic                   vsync_q, vsync_d;
   logic [1:0]             mode_q, mode_d;
   logic [7:0]             target_q, target_d;
   logic [15:0]            crc_q, crc_d;
   logic [15:0]            sig_q, sig_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic                   first_valid_q, first_valid_d;
   logic [9:0]             first_x_q, first_x_d;
   logic [9:0]             first_y_q, first_y_d;
   logic [7:0]             frame_count_q, frame_count_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;

   logic                   vsync_rise, vsync_fall;
   logic                   in_window, pix_take;
   logic [SUM_W-1:0]       diff_cnt, pix_inc, frame_inc, sum;
   logic [7:0]             frame_next;

   // Whole pixel is folded into the CRC in one clock, MSB first.
   function automatic logic [15:0] crc_update(input logic [15:0] crc, input logic [PIX_W-1:0] data);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = PIX_W - 1; i >= 0; i--) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   always_comb begin
      vsync_rise = Vsync & ~vsync_q;
      vsync_fall = ~Vsync & vsync_q;
      in_window  = Pixel_valid
                   && ($signed({22'd0, Pixel_X}) >= VIEW_LEFT)
                   && ($signed({22'd0, Pixel_X}) <  VIEW_RIGHT)
                   && ($signed({22'd0, Pixel_Y}) >= VIEW_TOP)
                   && ($signed({22'd0, Pixel_Y}) <  VIEW_BOTTOM);
      pix_take   = in_window && (state_q == S_CHECK);
      diff_cnt   = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (Pixel_data[ch*CH_WIDTH +: CH_WIDTH] != Expected_data[ch*CH_WIDTH +: CH_WIDTH])
            diff_cnt = diff_cnt + SUM_W'(1);
      end
      frame_next = frame_count_q + 8'd1;
   end

   always_comb begin
      state_d       = state_q;
      vsync_d       = Vsync;
      mode_d        = mode_q;
      target_d      = target_q;
      crc_d         = crc_q;
      sig_d         = sig_q;
      first_valid_d = first_valid_q;
      first_x_d     = first_x_q;
      first_y_d     = first_y_q;
      frame_count_d = frame_count_q;
      busy_d        = busy_q;
      done_d        = done_q;
      pass_d        = pass_q;
      pix_inc       = '0;
      frame_inc     = '0;

      if (pix_take && mode_q[0])
         pix_inc = diff_cnt;
      if (state_q == S_FRAME_END && mode_q[1] && crc_q != Golden_signature)
         frame_inc = SUM_W'(1);

      // Both increment sources are summed before saturating.
      sum = SUM_W'(count_q) + pix_inc + frame_inc;
      if (|sum[SUM_W-1:CNT_WIDTH])
         count_d = '1;
      else
         count_d = sum[CNT_WIDTH-1:0];

      if (pix_take) begin
         crc_d = crc_update(crc_q, Pixel_data);
         if (mode_q[0] && diff_cnt != '0 && !first_valid_q) begin
            first_valid_d = 1'b1;
            first_x_d     = Pixel_X;
            first_y_d     = Pixel_Y;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (Arm) begin
               mode_d        = Mode;
               target_d      = (Frames_to_check == 8'd0) ? 8'd1 : Frames_to_check;
               count_d       = '0;
               frame_count_d = 8'd0;
               first_valid_d = 1'b0;
               first_x_d     = 10'd0;
               first_y_d     = 10'd0;
               done_d        = 1'b0;
               pass_d        = 1'b0;
               busy_d        = 1'b1;
               state_d       = S_WAIT_FRAME;
            end
         end
         S_WAIT_FRAME: begin
            if (vsync_rise) begin
               crc_d   = 16'hFFFF;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (vsync_fall)
               state_d = S_FRAME_END;
         end
         S_FRAME_END: begin
            sig_d         = crc_q;
            frame_count_d = frame_next;
            if (frame_next == target_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (count_d == '0);
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT_FRAME;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q       <= S_IDLE;
         vsync_q       <= 1'b1;
         mode_q        <= 2'b00;
         target_q      <= 8'd0;
         crc_q         <= 16'hFFFF;
         sig_q         <= 16'hFFFF;
         count_q       <= '0;
         first_valid_q <= 1'b0;
         first_x_q     <= 10'd0;
         first_y_q     <= 10'd0;
         frame_count_q <= 8'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         vsync_q       <= vsync_d;
         mode_q        <= mode_d;
         target_q      <= target_d;
         crc_q         <= crc_d;
         sig_q         <= sig_d;
         count_q       <= count_d;
         first_valid_q <= first_valid_d;
         first_x_q     <= first_x_d;
         first_y_q     <= first_y_d;
         frame_count_q <= frame_count_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
      end
   end

   assign Busy           = busy_q;
   assign Done           = done_q;
   assign Pass           = pass_q;
   assign Mismatch_count = count_q;
   assign First_mm_valid = first_valid_q;
   assign First_mm_X     = first_x_q;
   assign First_mm_Y     = first_y_q;
   assign Signature      = sig_q;
   assign Frame_count    = frame_count_q;

endmodule

// File: tb/tb_vga_frame_checker.sv
// tb/tb_vga_frame_checker.sv - directed bench for vga_frame_checker on a 4x2 window with a 4-bit counter
module tb_vga_frame_checker;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Arm = 1'b0;
   logic [1:0]  Mode = 2'b00;
   logic [7:0]  Frames_to_check = 8'd0;
   logic [15:0] Golden_signature = 16'd0;
   logic        Vsync = 1'b1;
   logic        Pixel_valid = 1'b0;
   logic [9:0]  Pixel_X = 10'd0;
   logic [9:0]  Pixel_Y = 10'd0;
   logic [23:0] Pixel_data = 24'd0;
   logic [23:0] Expected_data = 24'd0;
   logic        Busy, Done, Pass, First_mm_valid;
   logic [3:0]  Mismatch_count;
   logic [9:0]  First_mm_X, First_mm_Y;
   logic [15:0] Signature;
   logic [7:0]  Frame_count;

   int vectors = 0;
   int miscompares = 0;
   logic [15:0] gold;

   always #5 Clock = ~Clock;

   vga_frame_checker #(
      .NUM_CH(3), .CH_WIDTH(8), .VIEW_LEFT(0), .VIEW_RIGHT(4),
      .VIEW_TOP(0), .VIEW_BOTTOM(2), .CNT_WIDTH(4)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Arm(Arm), .Mode(Mode),
      .Frames_to_check(Frames_to_check), .Golden_signature(Golden_signature),
      .Vsync(Vsync), .Pixel_valid(Pixel_valid), .Pixel_X(Pixel_X), .Pixel_Y(Pixel_Y),
      .Pixel_data(Pixel_data), .Expected_data(Expected_data),
      .Busy(Busy), .Done(Done), .Pass(Pass), .Mismatch_count(Mismatch_count),
      .First_mm_valid(First_mm_valid), .First_mm_X(First_mm_X), .First_mm_Y(First_mm_Y),
      .Signature(Signature), .Frame_count(Frame_count)
   );

   // Byte-wise CRC-16-CCITT reference over n identical 24-bit pixels.
   function automatic logic [15:0] crc_model(input logic [23:0] px, input int n);
      logic [15:0] c;
      logic [7:0]  b;
      logic [23:0] sh;
      c = 16'hFFFF;
      for (int p = 0; p < n; p++) begin
         for (int k = 0; k < 3; k++) begin
            sh = px >> (16 - 8 * k);
            b  = sh[7:0];
            c  = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++)
               c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
         end
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic arm(input logic [1:0] m, input logic [7:0] f, input logic [15:0] g);
      Mode = m;
      Frames_to_check = f;
      Golden_signature = g;
      Arm = 1'b1;
      tick();
      Arm = 1'b0;
   endtask

   // Scans a 6x3 raster so out-of-window pixels are also presented.
   task automatic frame(input logic [23:0] base,
                        input int bx0, input int by0, input logic [23:0] e0,
                        input int bx1, input int by1, input logic [23:0] e1);
      Vsync = 1'b0;
      tick();
      Vsync = 1'b1;
      tick();
      for (int y = 0; y < 3; y++) begin
         for (int x = 0; x < 6; x++) begin
            Pixel_valid   = 1'b1;
            Pixel_X       = 10'(x);
            Pixel_Y       = 10'(y);
            Pixel_data    = base;
            Expected_data = base ^ ((x == bx0 && y == by0) ? e0 : 24'h0)
                                 ^ ((x == bx1 && y == by1) ? e1 : 24'h0);
            tick();
         end
      end
      Pixel_valid = 1'b0;
      Vsync = 1'b0;
      tick();
      tick();
      tick();
   endtask

   initial begin
      tick();
      tick();
      Reset = 1'b0;
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_pass", 32'(Pass), 32'd0);
      chk("rst_cnt", 32'(Mismatch_count), 32'd0);
      chk("rst_sig", 32'(Signature), 32'hFFFF);
      chk("rst_frames", 32'(Frame_count), 32'd0);
      chk("rst_fmv", 32'(First_mm_valid), 32'd0);

      arm(2'b01, 8'd1, 16'h0);
      chk("t1_busy", 32'(Busy), 32'd1);
      frame(24'h123456, -1, -1, 24'h0, -1, -1, 24'h0);
      chk("t1_done", 32'(Done), 32'd1);
      chk("t1_pass", 32'(Pass), 32'd1);
      chk("t1_cnt", 32'(Mismatch_count), 32'd0);
      chk("t1_frames", 32'(Frame_count), 32'd1);
      chk("t1_busy_end", 32'(Busy), 32'd0);
      chk("t1_sig", 32'(Signature), 32'(crc_model(24'h123456, 8)));

      arm(2'b01, 8'd1, 16'h0);
      frame(24'h123456, 2, 1, 24'h010001, 5, 0, 24'hFFFFFF);
      chk("t2_cnt", 32'(Mismatch_count), 32'd2);
      chk("t2_fmv", 32'(First_mm_valid), 32'd1);
      chk("t2_fx", 32'(First_mm_X), 32'd2);
      chk("t2_fy", 32'(First_mm_Y), 32'd1);
      chk("t2_pass", 32'(Pass), 32'd0);

      arm(2'b01, 8'd1, 16'h0);
      chk("t2b_arm_cnt", 32'(Mismatch_count), 32'd0);
      chk("t2b_arm_fmv", 32'(First_mm_valid), 32'd0);
      frame(24'h123456, 2, 1, 24'h010001, 3, 1, 24'hFFFFFF);
      chk("t2b_cnt", 32'(Mismatch_count), 32'd5);
      chk("t2b_fx", 32'(First_mm_X), 32'd2);
      chk("t2b_fy", 32'(First_mm_Y), 32'd1);

      gold = crc_model(24'h000000, 8);
      arm(2'b10, 8'd1, gold);
      frame(24'h000000, 0, 0, 24'hFFFFFF, -1, -1, 24'h0);
      chk("t3_cnt", 32'(Mismatch_count), 32'd0);
      chk("t3_pass", 32'(Pass), 32'd1);
      chk("t3_sig", 32'(Signature), 32'(gold));
      arm(2'b10, 8'd1, gold ^ 16'h0001);
      frame(24'h000000, -1, -1, 24'h0, -1, -1, 24'h0);
      chk("t3b_cnt", 32'(Mismatch_count), 32'd1);
      chk("t3b_pass", 32'(Pass), 32'd0);

      arm(2'b00, 8'd1, 16'h0);
      frame(24'h123456, 1, 1, 24'hFFFFFF, -1, -1, 24'h0);
      chk("m0_cnt", 32'(Mismatch_count), 32'd0);
      chk("m0_pass", 32'(Pass), 32'd1);
      chk("m0_done", 32'(Done), 32'd1);

      arm(2'b01, 8'd0, 16'h0);
      frame(24'h123456, -1, -1, 24'h0, -1, -1, 24'h0);
      chk("t4_f0_done", 32'(Done), 32'd1);
      chk("t4_f0_frames", 32'(Frame_count), 32'd1);

      arm(2'b01, 8'd3, 16'h0);
      frame(24'h123456, -1, -1, 24'h0, -1, -1, 24'h0);
      chk("t4_f1", 32'(Frame_count), 32'd1);
      chk("t4_f1_done", 32'(Done), 32'd0);
      arm(2'b01, 8'd1, 16'h0);
      chk("t4_rearm_busy", 32'(Busy), 32'd1);
      chk("t4_rearm_frames", 32'(Frame_count), 32'd1);
      frame(24'h123456, -1, -1, 24'h0, -1, -1, 24'h0);
      chk("t4_f2", 32'(Frame_count), 32'd2);
      chk("t4_f2_done", 32'(Done), 32'd0);
      frame(24'h123456, -1, -1, 24'h0, -1, -1, 24'h0);
      chk("t4_f3", 32'(Frame_count), 32'd3);
      chk("t4_f3_done", 32'(Done), 32'd1);
      chk("t4_f3_pass", 32'(Pass), 32'd1);

      arm(2'b01, 8'd6, 16'h0);
      for (int f = 0; f < 4; f++)
         frame(24'h123456, 0, 0, 24'hFFFFFF, -1, -1, 24'h0);
      chk("t5_cnt4", 32'(Mismatch_count), 32'd12);
      frame(24'h123456, 0, 0, 24'hFFFFFF, -1, -1, 24'h0);
      chk("t5_cnt5", 32'(Mismatch_count), 32'd15);
      frame(24'h123456, 0, 0, 24'hFFFFFF, -1, -1, 24'h0);
      chk("t5_sat", 32'(Mismatch_count), 32'hF);
      chk("t5_done", 32'(Done), 32'd1);
      chk("t5_pass", 32'(Pass), 32'd0);
      chk("t5_frames", 32'(Frame_count), 32'd6);

      arm(2'b01, 8'd1, 16'h0);
      Vsync = 1'b0;
      tick();
      Vsync = 1'b1;
      tick();
      Pixel_valid = 1'b1;
      Pixel_X = 10'd0;
      Pixel_Y = 10'd0;
      Pixel_data = 24'h123456;
      Expected_data = 24'hEDCBA9;
      tick();
      Pixel_valid = 1'b0;
      tick();
      chk("t6_pre_cnt", 32'(Mismatch_count), 32'd3);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("t6_busy", 32'(Busy), 32'd0);
      chk("t6_cnt", 32'(Mismatch_count), 32'd0);
      chk("t6_sig", 32'(Signature), 32'hFFFF);
      chk("t6_fmv", 32'(First_mm_valid), 32'd0);
      frame(24'h123456, 0, 0, 24'hFFFFFF, -1, -1, 24'h0);
      chk("t6_post_cnt", 32'(Mismatch_count), 32'd0);
      chk("t6_post_frames", 32'(Frame_count), 32'd0);
      chk("t6_post_done", 32'(Done), 32'd0);
      chk("t6_post_sig", 32'(Signature), 32'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_frame_checker.md
Name: vga_frame_checker

Overview:
- Synthesizable on-chip successor to the bench-side VGA self-check: monitors the VGA pixel stream, compares pixels against an expected stream and/or a per-frame CRC-16 signature over a parametrised view window.
- Sits beside VGA_unit in project; results drive LEDs/seven-segment so pass/fail is visible on the board without simulation.
- Generalised in channel count, channel width, window geometry and frame count, with a run state machine and signature mode.

Parameters:
- NUM_CH, 3, number of colour channels per pixel
- CH_WIDTH, 8, bits per channel
- VIEW_LEFT, 160, first in-window column (inclusive)
- VIEW_RIGHT, 480, last in-window column (exclusive)
- VIEW_TOP, 120, first in-window row (inclusive)
- VIEW_BOTTOM, 360, last in-window row (exclusive)
- CNT_WIDTH, 16, mismatch counter width

Ports:
- Clock  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- Arm  in  1  one-cycle pulse; starts a run
- Mode  in  2  [0] = pixel compare enable, [1] = signature compare enable
- Frames_to_check  in  8  number of frames per run; 0 treated as 1
- Golden_signature  in  16  expected per-frame CRC
- Vsync  in  1  VGA vertical sync, active low
- Pixel_valid  in  1  pixel strobe (every other clock in 640x480 mode)
- Pixel_X  in  10  column of current pixel
- Pixel_Y  in  10  row of current pixel
- Pixel_data  in  NUM_CH*CH_WIDTH  observed pixel, channel 0 in MSBs
- Expected_data  in  NUM_CH*CH_WIDTH  expected pixel, same alignment
- Busy  out  1  run in progress
- Done  out  1  run complete; held high
- Pass  out  1  valid when Done
- Mismatch_count  out  CNT_WIDTH  accumulated mismatches, saturating
- First_mm_valid  out  1  first mismatch captured
- First_mm_X  out  10  column of first pixel mismatch
- First_mm_Y  out  10  row of first pixel mismatch
- Signature  out  16  CRC of last completed frame
- Frame_count  out  8  frames completed in this run

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Reset clears all outputs to 0, Signature to 16'hFFFF, state to S_IDLE, and the Vsync edge register to 1, so no false edge is seen after reset.
- Edge detect: Vsync registered once. Rising edge (1 after 0) = frame start; falling edge = frame end.
- States:
  - S_IDLE: Arm latches Mode and max(Frames_to_check,1), clears counters, First_mm_*, Done and Pass, sets Busy, then -> S_WAIT_FRAME.
  - S_WAIT_FRAME: rising edge -> S_CHECK, with the CRC accumulator set to 16'hFFFF.
  - S_CHECK: on a falling edge -> S_FRAME_END.
  - S_FRAME_END: one cycle. Signature <= accumulator. If Mode[1] and accumulator != Golden_signature, Mismatch_count +1 (saturating). Frame_count +1. If Frame_count+1 == target -> S_DONE, else -> S_WAIT_FRAME.
  - S_DONE: Busy=0, Done=1, Pass = (Mismatch_count==0). Arm -> behaves as in S_IDLE (new run).
- In-window pixel: Pixel_valid && VIEW_LEFT<=X<VIEW_RIGHT && VIEW_TOP<=Y<VIEW_BOTTOM. It is processed only in S_CHECK; all other pixels are ignored.
- CRC: CRC-16-CCITT, poly 0x1021, no reflection, no final XOR. Pixel_data is shifted in MSB-first, all NUM_CH*CH_WIDTH bits in one clock. Updated one cycle after the pixel.
- Pixel compare (Mode[0]): per channel, increment by the number of differing channels (0..NUM_CH). Saturate at all-ones. Registered, 1-cycle latency.
- First mismatch: on the first mismatching in-window pixel of the run, capture X/Y and set First_mm_valid. Later mismatches do not overwrite it.
- Mode 2'b00: run still counts frames and computes Signature; Pass=1.
- Arm while Busy: ignored.
- Rising edge in S_CHECK without a falling edge between: ignored.
- Pixel and frame-end increments in the same cycle: both applied, sum saturates.
- Reset mid-run: immediate return to the reset state; no partial results kept.

Test Plan:
- Window 4x2 (LEFT=0, RIGHT=4, TOP=0, BOTTOM=2), Mode=01, Frames_to_check=1, Expected_data==Pixel_data -> Done=1, Pass=1, Mismatch_count=0, Frame_count=1.
- Same setup, pixel (2,1) with channel 0 and channel 2 wrong -> Mismatch_count=2, First_mm_X=2, First_mm_Y=1, Pass=0. A second bad pixel (3,1) leaves First_mm unchanged.
- Mode=10, all 8 window pixels = 24'h000000, Golden = reference-model CRC -> Pass=1, Signature=Golden. Flip one bit of Golden -> Mismatch_count=1, Pass=0.
- Frames_to_check=0 -> run ends after 1 frame. Frames_to_check=3 -> Frame_count steps 1,2,3; Done only after the third falling edge; Arm pulsed mid-run is ignored.
- CNT_WIDTH=4, 6 frames of 3-channel mismatches -> Mismatch_count holds at 4'hF, no wrap.
- Reset asserted in S_CHECK -> next cycle Busy=0, Mismatch_count=0, Signature=16'hFFFF. Pixels before the next Arm change nothing.
